// File: rtl/fifo_ctrl_sync_if.sv
// fifo_ctrl_sync_if: request/flag/memory-control bundle for fifo_ctrl_sync.
// Optional error flags present when FIFO_CTRL_ERR_FLAG_EN is defined.
interface fifo_ctrl_sync_if #(
  parameter int p_nbit_a = 4
);
  logic                flush;
  logic                wr_req;
  logic                rd_req;
  logic                full;
  logic                empty;
  logic                afull;
  logic [p_nbit_a:0]   count;
  logic                mem_wr;
  logic [p_nbit_a-1:0] mem_waddr;
  logic                mem_rd;
  logic [p_nbit_a-1:0] mem_raddr;
  logic                rvalid;
`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic                err_ovf;
  logic                err_udf;

  modport master (
    output flush, wr_req, rd_req,
    input  full, empty, afull, count,
    input  mem_wr, mem_waddr, mem_rd, mem_raddr,
    input  rvalid, err_ovf, err_udf
  );

  modport slave (
    input  flush, wr_req, rd_req,
    output full, empty, afull, count,
    output mem_wr, mem_waddr, mem_rd, mem_raddr,
    output rvalid, err_ovf, err_udf
  );
`else
  modport master (
    output flush, wr_req, rd_req,
    input  full, empty, afull, count,
    input  mem_wr, mem_waddr, mem_rd, mem_raddr,
    input  rvalid
  );

  modport slave (
    input  flush, wr_req, rd_req,
    output full, empty, afull, count,
    output mem_wr, mem_waddr, mem_rd, mem_raddr,
    output rvalid
  );
`endif
endinterface

// File: rtl/fifo_ctrl_sync.sv
// fifo_ctrl_sync: single-clock FIFO pointer/flag controller.
// Define FIFO_CTRL_ERR_FLAG_EN to add sticky err_ovf/err_udf flags.
module fifo_ctrl_sync #(
  parameter int p_nbit_a        = 4,
  parameter bit p_output_reg_en = 1'b1,
  parameter int p_afull_th      = 12
) (
  input logic             clk,
  input logic             rst,
  fifo_ctrl_sync_if.slave bus
);
  localparam int AW = p_nbit_a;
  localparam logic [AW:0] DEPTH = (AW+1)'(2**AW);
  localparam logic [AW:0] AFTH  = (AW+1)'(p_afull_th);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] count;
  logic [AW:0] cnt_nxt;
  logic        full;
  logic        empty;
  logic        afull;
  logic [1:0]  vpipe;
  logic        wa;
  logic        ra;

  // flush/rst squash both accepts so memory is never touched
  assign wa = bus.wr_req & ~full & ~bus.flush & ~rst;
  assign ra = bus.rd_req & ~empty & ~bus.flush & ~rst;

  assign cnt_nxt = count
                 + {{AW{1'b0}}, wa}
                 - {{AW{1'b0}}, ra};

  // pointers, count, flags and read-valid pipeline
  always_ff @(posedge clk) begin
    if (rst | bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
      afull <= 1'b0;
      vpipe <= '0;
    end else begin
      wptr  <= wptr + {{AW{1'b0}}, wa};
      rptr  <= rptr + {{AW{1'b0}}, ra};
      count <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == DEPTH);
      afull <= (cnt_nxt >= AFTH);
      vpipe <= {vpipe[0], ra};
    end
  end

  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.afull     = afull;
  assign bus.count     = count;
  assign bus.mem_wr    = wa;
  assign bus.mem_rd    = ra;
  assign bus.mem_waddr = wptr[AW-1:0];
  assign bus.mem_raddr = rptr[AW-1:0];
  assign bus.rvalid    = p_output_reg_en ? vpipe[1]
                                         : vpipe[0];

`ifdef FIFO_CTRL_ERR_FLAG_EN
  logic err_ovf;
  logic err_udf;

  // sticky overflow/underflow, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (bus.wr_req & full)
        err_ovf <= 1'b1;
      if (bus.rd_req & empty)
        err_udf <= 1'b1;
    end
  end

  assign bus.err_ovf = err_ovf;
  assign bus.err_udf = err_udf;
`endif
endmodule

// File: tb/tb_fifo_ctrl_sync.sv
// tb_fifo_ctrl_sync: vector table plus rvalid scoreboard,
// two instances (read latency 2 and 1) driven identically.
module tb_fifo_ctrl_sync;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fifo_ctrl_sync_if #(.p_nbit_a(AW)) b1 ();
  fifo_ctrl_sync_if #(.p_nbit_a(AW)) b0 ();

  fifo_ctrl_sync #(
    .p_nbit_a(AW),
    .p_output_reg_en(1'b1),
    .p_afull_th(12)
  ) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  fifo_ctrl_sync #(
    .p_nbit_a(AW),
    .p_output_reg_en(1'b0),
    .p_afull_th(12)
  ) u0 (
    .clk(clk),
    .rst(rst),
    .bus(b0.slave)
  );

  typedef struct {
    logic wr;
    logic rd;
    logic fl;
    logic mw;
    logic mr;
    int   cnt;
  } vec_t;

  vec_t vt[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   q1[$];
  int   q0[$];
  int   wexp = 0;
  int   rexp = 0;

  function automatic void add(logic wr, logic rd,
                              logic fl, logic mw,
                              logic mr, int cnt);
    vec_t v;
    v.wr = wr; v.rd = rd; v.fl = fl;
    v.mw = mw; v.mr = mr; v.cnt = cnt;
    vt.push_back(v);
  endfunction

  function automatic logic [31:0] est(int c);
    logic [4:0] cw;
    cw = 5'(c);
    return {24'd0, cw, (c == 0), (c == 16), (c >= 12)};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic wr, logic rd, logic fl);
    b1.wr_req = wr; b1.rd_req = rd; b1.flush = fl;
    b0.wr_req = wr; b0.rd_req = rd; b0.flush = fl;
  endtask

  task automatic chk_rv(string tag);
    logic e1;
    logic e0;
    e1 = (q1.size() > 0 && q1[0] == cyc);
    e0 = (q0.size() > 0 && q0[0] == cyc);
    if (e1) void'(q1.pop_front());
    if (e0) void'(q0.pop_front());
    chk({tag, " rvalid_l2"}, 32'(b1.rvalid), 32'(e1));
    chk({tag, " rvalid_l1"}, 32'(b0.rvalid), 32'(e0));
  endtask

  task automatic chk_state(string tag, int c);
    chk({tag, " state_l2"},
        {24'd0, b1.count, b1.empty, b1.full, b1.afull},
        est(c));
    chk({tag, " state_l1"},
        {24'd0, b0.count, b0.empty, b0.full, b0.afull},
        est(c));
  endtask

  task automatic step(vec_t v, int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(v.wr, v.rd, v.fl);
    if (v.fl) begin
      q1.delete();
      q0.delete();
    end
    #1;
    chk({tag, " mem_wr"}, {30'd0, b1.mem_wr, b0.mem_wr},
        {30'd0, v.mw, v.mw});
    chk({tag, " mem_rd"}, {30'd0, b1.mem_rd, b0.mem_rd},
        {30'd0, v.mr, v.mr});
    if (v.mw) begin
      chk({tag, " waddr"}, {24'd0, b1.mem_waddr, b0.mem_waddr},
          {24'd0, 4'(wexp % 16), 4'(wexp % 16)});
      wexp++;
    end
    if (v.mr) begin
      chk({tag, " raddr"}, {24'd0, b1.mem_raddr, b0.mem_raddr},
          {24'd0, 4'(rexp % 16), 4'(rexp % 16)});
      rexp++;
      q1.push_back(cyc + 2);
      q0.push_back(cyc + 1);
    end
    if (v.fl) begin
      wexp = 0;
      rexp = 0;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk_state(tag, v.cnt);
    chk_rv(tag);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) add(1, 0, 0, 1, 0, i + 1);
    add(1, 0, 0, 0, 0, 16);
    for (int i = 0; i < 16; i++) add(0, 1, 0, 0, 1, 15 - i);
    add(0, 1, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 1);
    for (int i = 0; i < 7; i++) add(1, 0, 0, 1, 0, i + 2);
    for (int i = 0; i < 20; i++) add(1, 1, 0, 1, 1, 8);
    for (int i = 0; i < 8; i++) add(1, 0, 0, 1, 0, i + 9);
    add(1, 1, 0, 0, 1, 15);
    for (int i = 0; i < 10; i++) add(0, 1, 0, 0, 1, 14 - i);
    add(1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 0, 1);
    add(1, 0, 0, 1, 0, 2);
    add(0, 1, 0, 0, 1, 1);

    rst = 1'b1;
    drive(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk_state("reset", 0);
    chk("reset rvalid", {30'd0, b1.rvalid, b0.rvalid}, 32'd0);
    chk("reset mem_wr", {30'd0, b1.mem_wr, b0.mem_wr}, 32'd0);
`ifdef FIFO_CTRL_ERR_FLAG_EN
    chk("reset err",
        {28'd0, b1.err_ovf, b1.err_udf, b0.err_ovf, b0.err_udf},
        32'd0);
`endif
    rst = 1'b0;
    cyc = 0;

    for (int i = 0; i < vt.size(); i++) step(vt[i], i);

`ifdef FIFO_CTRL_ERR_FLAG_EN
    chk("err after flush",
        {28'd0, b1.err_ovf, b1.err_udf, b0.err_ovf, b0.err_udf},
        32'hf);
`endif

    drive(1, 1, 0);
    rst = 1'b1;
    q1.delete();
    q0.delete();
    @(posedge clk);
    cyc++;
    #1;
    chk_state("midrst", 0);
    chk_rv("midrst");
`ifdef FIFO_CTRL_ERR_FLAG_EN
    chk("err after rst",
        {28'd0, b1.err_ovf, b1.err_udf, b0.err_ovf, b0.err_udf},
        32'd0);
`endif
    rst = 1'b0;
    drive(0, 0, 0);
    repeat (3) begin
      @(posedge clk);
      cyc++;
      #1;
      chk_rv("post_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
